crc_stream_append: RTL and testbench

- Byte-stream CRC engine with valid/ready handshakes on input and output. It generalises our fixed CRC-16 byte-parallel generator.
- Polynomial, width, init, reflection and final XOR are parameters.
- Append mode: forwards the frame and then appends the CRC bytes. Check mode: forwards the frame, which already carries its CRC, and reports pass/fail.
- Sits between packet sources (UART/SPI framers) and link outputs.

---
 rtl/crc_pkg.sv | 64 ++++++
 rtl/crc_byte_step.sv | 19 +
 rtl/crc_stream_append.sv | 148 ++++++++++++++
 tb/tb_crc_stream_append.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and bit-level CRC helpers
// for the byte-stream CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    APPEND
  } state_t;

  // Reverse the low w bits of v.
  function automatic logic [31:0] bit_reverse(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        t = v >> (w - 1 - i);
        r = r | ({31'b0, t[0]} << i);
      end
    end
    return r;
  endfunction

  // Advance a w-bit CRC register by one byte.
  // reflect=1 shifts right and consumes the
  // byte LSB first against the mirrored poly.
  function automatic logic [31:0] crc_step8(
    input logic [31:0] crc,
    input logic [7:0]  b,
    input logic [31:0] poly,
    input logic        reflect,
    input int          w
  );
    logic [31:0] mask;
    logic [31:0] rp;
    logic [31:0] c;
    logic [31:0] top;
    logic [7:0]  bs;
    logic        fb;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    rp   = bit_reverse(poly, w);
    c    = crc & mask;
    for (int i = 0; i < 8; i++) begin
      if (reflect) begin
        bs = b >> i;
        fb = c[0] ^ bs[0];
        c  = c >> 1;
        if (fb) c = c ^ rp;
      end else begin
        bs  = b << i;
        top = c >> (w - 1);
        fb  = top[0] ^ bs[7];
        c   = (c << 1) & mask;
        if (fb) c = c ^ (poly & mask);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One-byte combinational CRC update,
// fully unrolled over the eight bit steps.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int             CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY  = 'h8005,
  parameter bit             REFLECT = 1'b0
) (
  input  logic [CRC_W-1:0] crc,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] nxt
);

  // Register value after absorbing data.
  assign nxt = CRC_W'(crc_step8(32'(crc), data,
                 32'(POLY), REFLECT, CRC_W));

endmodule

// File: rtl/crc_stream_append.sv
// Byte-stream CRC: append a trailer to a frame
// or check a frame that already carries one.
module crc_stream_append
  import crc_pkg::*;
#(
  parameter int               CRC_W         = 16,
  parameter logic [CRC_W-1:0] POLY          = 'h8005,
  parameter logic [CRC_W-1:0] INIT          = '0,
  parameter logic [CRC_W-1:0] XOR_OUT       = '0,
  parameter bit               REFLECT       = 1'b0,
  parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic             stat_short,
  output logic [CRC_W-1:0] crc_value
);

  localparam int NB = CRC_W / 8;

  state_t           state;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_prior;
  logic [CRC_W-1:0] crc_nxt;
  logic [CRC_W-1:0] crc_fin;
  logic [CRC_W-1:0] crc_out;
  logic [CRC_W-1:0] pend_crc;
  logic [7:0]       cnt;
  logic [7:0]       cnt_nxt;
  logic [1:0]       idx;
  logic [1:0]       sel;
  logic             mode_q;
  logic             cur_mode;
  logic             first;
  logic             load;
  logic             acc;
  logic             is_short;
  logic             pend_ok;
  logic             pend_short;

  assign load      = !m_valid || m_ready;
  assign s_ready   = (state != APPEND) && load;
  assign acc       = s_valid && s_ready;
  assign first     = (state == IDLE);
  assign cur_mode  = first ? mode : mode_q;
  assign crc_prior = first ? INIT : crc_q;
  assign crc_fin   = crc_nxt ^ XOR_OUT;
  assign cnt_nxt   = first ? 8'd1 :
                     (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign is_short  = cur_mode && (cnt_nxt <= 8'(NB));
  assign sel       = REFLECT ? 2'(NB - 1) - idx : idx;

  crc_byte_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .REFLECT(REFLECT)
  ) u_step (
    .crc (crc_prior),
    .data(s_data),
    .nxt (crc_nxt)
  );

  // Frame FSM, output register and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      crc_q      <= INIT;
      crc_out    <= '0;
      pend_crc   <= '0;
      pend_ok    <= 1'b0;
      pend_short <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      mode_q     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      stat_valid <= 1'b0;
      stat_ok    <= 1'b0;
      stat_short <= 1'b0;
      crc_value  <= '0;
    end else begin
      stat_valid <= 1'b0;
      if (m_valid && m_ready && m_last) begin
        stat_valid <= 1'b1;
        stat_ok    <= pend_ok;
        stat_short <= pend_short;
        crc_value  <= pend_crc;
      end
      if (m_ready) m_valid <= 1'b0;
      unique case (state)
        IDLE, DATA: begin
          if (acc) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            cnt     <= cnt_nxt;
            if (first) mode_q <= mode;
            if (!s_last) begin
              m_last <= 1'b0;
              crc_q  <= crc_nxt;
              state  <= DATA;
            end else begin
              crc_q      <= INIT;
              cnt        <= '0;
              pend_short <= is_short;
              if (cur_mode) begin
                m_last   <= 1'b1;
                pend_crc <= crc_nxt;
                pend_ok  <= !is_short &&
                            (crc_nxt == CHECK_RESIDUE);
                state    <= IDLE;
              end else begin
                m_last   <= 1'b0;
                pend_crc <= crc_fin;
                pend_ok  <= 1'b1;
                crc_out  <= crc_fin;
                idx      <= 2'(NB - 1);
                state    <= APPEND;
              end
            end
          end
        end
        APPEND: begin
          if (load) begin
            m_valid <= 1'b1;
            m_data  <= 8'(crc_out >> {sel, 3'b000});
            m_last  <= (idx == 2'd0);
            if (idx == 2'd0) state <= IDLE;
            else idx <= idx - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_append.sv
// Scoreboard bench for crc_stream_append:
// CRC-16/BUYPASS and CRC-32 instances.
module tb_crc_stream_append;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic        ok;
    logic        sh;
    logic [31:0] cv;
  } stat_t;

  localparam logic [31:0] RES32 = 32'hDEBB20E3;

  logic        clk;
  logic        rst_n;
  logic        mode[2];
  logic        s_valid[2];
  logic        s_ready[2];
  logic [7:0]  s_data[2];
  logic        s_last[2];
  logic        m_valid[2];
  logic        m_ready[2];
  logic [7:0]  m_data[2];
  logic        m_last[2];
  logic        stat_valid[2];
  logic        stat_ok[2];
  logic        stat_short[2];
  logic [15:0] cv0;
  logic [31:0] cv1;

  int    checks = 0;
  int    errors = 0;
  bit    bp = 0;
  beat_t eq0[$];
  beat_t eq1[$];
  stat_t sq0[$];
  stat_t sq1[$];
  bit    pv[2];
  bit    pr[2];
  logic [7:0] pd[2];
  logic  pl[2];

  crc_stream_append u0 (
    .clk(clk), .rst_n(rst_n), .mode(mode[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_last(s_last[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .m_last(m_last[0]),
    .stat_valid(stat_valid[0]), .stat_ok(stat_ok[0]),
    .stat_short(stat_short[0]), .crc_value(cv0)
  );

  crc_stream_append #(
    .CRC_W(32), .POLY(32'h04C11DB7),
    .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
    .REFLECT(1'b1), .CHECK_RESIDUE(RES32)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_last(s_last[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .m_last(m_last[1]),
    .stat_valid(stat_valid[1]), .stat_ok(stat_ok[1]),
    .stat_short(stat_short[1]), .crc_value(cv1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Instance parameters as seen by the model.
  task automatic prm(input int k, output int w,
    output logic [31:0] p, output logic [31:0] i,
    output logic [31:0] x, output bit r,
    output logic [31:0] res);
    if (k == 0) begin
      w = 16; p = 32'h8005; i = 0; x = 0; r = 0; res = 0;
    end else begin
      w = 32; p = 32'h04C11DB7; i = 32'hFFFFFFFF;
      x = 32'hFFFFFFFF; r = 1; res = RES32;
    end
  endtask

  function automatic logic [31:0] rev(
    input logic [31:0] v, input int w);
    logic [31:0] o = 0;
    for (int j = 0; j < w; j++) o[w-1-j] = v[j];
    return o;
  endfunction

  // CRC register contents as polynomial long
  // division of the init-adjusted, augmented
  // message bit string.
  function automatic logic [31:0] model_reg(
    input logic [7:0] msg[$], input int w,
    input logic [31:0] poly, input logic [31:0] init,
    input bit refl);
    bit b[$];
    logic [31:0] in_n, r;
    int L;
    foreach (msg[m])
      for (int q = 0; q < 8; q++)
        b.push_back(refl ? msg[m][q] : msg[m][7-q]);
    for (int j = 0; j < w; j++) b.push_back(1'b0);
    in_n = refl ? rev(init, w) : init;
    for (int j = 0; j < w; j++) b[j] = b[j] ^ in_n[w-1-j];
    L = b.size();
    for (int i = 0; i < L - w; i++)
      if (b[i])
        for (int j = 0; j <= w; j++)
          b[i+j] = b[i+j] ^ ((j == 0) ? 1'b1 : poly[w-j]);
    r = 0;
    for (int j = 0; j < w; j++) r[w-1-j] = b[L-w+j];
    return refl ? rev(r, w) : r;
  endfunction

  task automatic push_b(input int k, input logic [7:0] d,
                        input logic l);
    beat_t e;
    e.d = d; e.l = l;
    if (k == 0) eq0.push_back(e); else eq1.push_back(e);
  endtask

  task automatic push_s(input int k, input logic ok,
                        input logic sh, input logic [31:0] cv);
    stat_t e;
    e.ok = ok; e.sh = sh; e.cv = cv;
    if (k == 0) sq0.push_back(e); else sq1.push_back(e);
  endtask

  // Expected output beats and status of a frame.
  task automatic exp_frame(input int k, input bit md,
                           input logic [7:0] msg[$]);
    int w, nb;
    logic [31:0] p, i, x, res, raw, c;
    bit r, sh;
    prm(k, w, p, i, x, r, res);
    nb  = w / 8;
    raw = model_reg(msg, w, p, i, r);
    if (md) begin
      foreach (msg[j]) push_b(k, msg[j], j == msg.size() - 1);
      sh = (msg.size() <= nb);
      push_s(k, !sh && (raw == res), sh, raw);
    end else begin
      c = raw ^ x;
      foreach (msg[j]) push_b(k, msg[j], 1'b0);
      for (int j = 0; j < nb; j++)
        push_b(k, 8'(c >> (8 * (r ? j : nb - 1 - j))),
               j == nb - 1);
      push_s(k, 1'b1, 1'b0, c);
    end
  endtask

  // Drive one frame; mode is noise after beat 0.
  task automatic send(input int k, input bit md,
                      input logic [7:0] msg[$], input bit gaps);
    bit acc;
    int n;
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps) begin
        s_valid[k] = 0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      s_valid[k] = 1;
      s_data[k]  = msg[i];
      s_last[k]  = (i == msg.size() - 1);
      mode[k]    = (i == 0) ? md : 1'($urandom_range(0, 1));
      acc = 0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_ready[k];
        @(posedge clk); #1;
        n++;
        if (!acc && n > 1000) begin
          checks++; errors++;
          $display("FAIL accept_timeout inst%0d beat %0d", k, i);
          s_valid[k] = 0;
          return;
        end
      end
    end
    s_valid[k] = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((eq0.size() + eq1.size() + sq0.size()
            + sq1.size()) != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain left %0d/%0d beats %0d/%0d stats",
               eq0.size(), eq1.size(), sq0.size(), sq1.size());
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  // Monitor: compare every handshake and status pulse.
  task automatic mon(input int k);
    logic mv, mr, ml, sv;
    logic [7:0] md;
    logic [31:0] cv;
    beat_t e;
    stat_t s;
    bit have;
    mv = m_valid[k]; mr = m_ready[k];
    md = m_data[k];  ml = m_last[k];
    sv = stat_valid[k];
    cv = (k == 0) ? 32'(cv0) : cv1;
    if (pv[k] && !pr[k]) begin
      checks++;
      if (mv !== 1'b1 || md !== pd[k] || ml !== pl[k]) begin
        errors++;
        $display("FAIL stall_hold inst%0d got v%0b %02h l%0b want v1 %02h l%0b",
                 k, mv, md, ml, pd[k], pl[k]);
      end
    end
    if (mv && mr) begin
      checks++;
      have = (k == 0) ? (eq0.size() != 0) : (eq1.size() != 0);
      if (!have) begin
        errors++;
        $display("FAIL out_extra inst%0d got %02h l%0b want none",
                 k, md, ml);
      end else begin
        if (k == 0) e = eq0.pop_front();
        else e = eq1.pop_front();
        if (md !== e.d || ml !== e.l) begin
          errors++;
          $display("FAIL out_beat inst%0d got %02h l%0b want %02h l%0b",
                   k, md, ml, e.d, e.l);
        end
      end
    end
    if (sv) begin
      checks++;
      have = (k == 0) ? (sq0.size() != 0) : (sq1.size() != 0);
      if (!have) begin
        errors++;
        $display("FAIL stat_extra inst%0d got ok%0b sh%0b %0h",
                 k, stat_ok[k], stat_short[k], cv);
      end else begin
        if (k == 0) s = sq0.pop_front();
        else s = sq1.pop_front();
        if (stat_ok[k] !== s.ok || stat_short[k] !== s.sh
            || cv !== s.cv) begin
          errors++;
          $display("FAIL stat inst%0d got ok%0b sh%0b %0h want ok%0b sh%0b %0h",
                   k, stat_ok[k], stat_short[k], cv, s.ok, s.sh, s.cv);
        end
      end
    end
    pv[k] = mv; pr[k] = mr; pd[k] = md; pl[k] = ml;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end else begin
      pv[0] = 0;
      pv[1] = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      m_ready[0] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready[1] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [7:0] msg[$];
    logic [7:0] num[$];
    logic [31:0] raw;
    int n, w, nb;
    logic [31:0] p, i, x, res;
    bit r, md;

    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; s_valid[k] = 0; s_data[k] = 0;
      s_last[k] = 0; m_ready[k] = 1;
    end
    for (int j = 0; j < 9; j++) num.push_back(8'h31 + 8'(j));
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cmp("rst_m_valid", 32'(m_valid[k]), 0);
      cmp("rst_m_last", 32'(m_last[k]), 0);
      cmp("rst_m_data", 32'(m_data[k]), 0);
      cmp("rst_stat_valid", 32'(stat_valid[k]), 0);
      cmp("rst_stat_ok", 32'(stat_ok[k]), 0);
      cmp("rst_stat_short", 32'(stat_short[k]), 0);
    end
    cmp("rst_crc0", 32'(cv0), 0);
    cmp("rst_crc1", cv1, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // CRC-16 append of the check string.
    foreach (num[j]) push_b(0, num[j], 0);
    push_b(0, 8'hFE, 0);
    push_b(0, 8'hE8, 1);
    push_s(0, 1, 0, 32'hFEE8);
    send(0, 0, num, 0);
    drain();

    // CRC-16 check mode, good then corrupted.
    msg = num; msg.push_back(8'hFE); msg.push_back(8'hE8);
    foreach (msg[j]) push_b(0, msg[j], j == 10);
    push_s(0, 1, 0, 32'h0000);
    send(0, 1, msg, 0);
    msg[10] = 8'hE9;
    foreach (msg[j]) push_b(0, msg[j], j == 10);
    push_s(0, 0, 0, 32'h8005);
    send(0, 1, msg, 0);
    drain();

    // Short check frame and a one-byte append.
    msg = '{8'h12, 8'h34};
    foreach (msg[j]) push_b(0, msg[j], j == 1);
    push_s(0, 0, 1, model_reg(msg, 16, 32'h8005, 0, 0));
    send(0, 1, msg, 0);
    msg = '{8'h00};
    push_b(0, 8'h00, 0);
    push_b(0, 8'h00, 0);
    push_b(0, 8'h00, 1);
    push_s(0, 1, 0, 0);
    send(0, 0, msg, 0);
    drain();

    // CRC-32 append, then check the result.
    foreach (num[j]) push_b(1, num[j], 0);
    push_b(1, 8'h26, 0);
    push_b(1, 8'h39, 0);
    push_b(1, 8'hF4, 0);
    push_b(1, 8'hCB, 1);
    push_s(1, 1, 0, 32'hCBF43926);
    send(1, 0, num, 0);
    msg = num;
    msg.push_back(8'h26); msg.push_back(8'h39);
    msg.push_back(8'hF4); msg.push_back(8'hCB);
    exp_frame(1, 1, msg);
    send(1, 1, msg, 0);
    drain();

    // Reset after the first trailer byte.
    foreach (num[j]) push_b(0, num[j], 0);
    push_b(0, 8'hFE, 0);
    send(0, 0, num, 0);
    n = 0;
    while (eq0.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    cmp("pre_reset_drain", 32'(eq0.size()), 0);
    rst_n = 0;
    #1;
    cmp("mid_rst_m_valid", 32'(m_valid[0]), 0);
    cmp("mid_rst_m_last", 32'(m_last[0]), 0);
    cmp("mid_rst_m_data", 32'(m_data[0]), 0);
    cmp("mid_rst_crc", 32'(cv0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    foreach (num[j]) push_b(0, num[j], 0);
    push_b(0, 8'hFE, 0);
    push_b(0, 8'hE8, 1);
    push_s(0, 1, 0, 32'hFEE8);
    send(0, 0, num, 0);
    drain();

    // Random frames, gaps and backpressure.
    bp = 1;
    for (int k = 0; k < 2; k++) begin
      prm(k, w, p, i, x, r, res);
      nb = w / 8;
      for (int f = 0; f < ((k == 0) ? 100 : 30); f++) begin
        msg.delete();
        n  = $urandom_range(1, 64);
        md = 1'($urandom_range(0, 1));
        for (int j = 0; j < n; j++)
          msg.push_back(8'($urandom));
        if (md && $urandom_range(0, 1) == 1) begin
          raw = model_reg(msg, w, p, i, r) ^ x;
          for (int j = 0; j < nb; j++)
            msg.push_back(8'(raw >> (8 * (r ? j : nb - 1 - j))));
        end
        exp_frame(k, md, msg);
        send(k, md, msg, 1);
      end
      drain();
    end
    bp = 0;
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
